// File: rtl/fifo_master_pkg.sv
// fifo_master_pkg
//   Shared definitions for the fifo initiator: FSM state encodings, the bit
//   positions inside the sticky error vector, and a width helper. The fifo
//   bench reuses the same encodings so both sides agree on what they see.
package fifo_master_pkg;

  // Transaction FSM states. Exactly one fifo transaction is outstanding at a time.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SET_WAIT = 2'd1,
    ST_GET_WAIT = 2'd2,
    ST_DONE     = 2'd3
  } fm_state_e;

  // Bit indices into o_err.
  localparam int ERR_OVUN    = 0;  // overflow or underflow refusal
  localparam int ERR_TIMEOUT = 1;  // ack never arrived

  // Bits needed to hold the values 0..n inclusive.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fifo_master_ack_timer.sv
// ack_timer
//   Loadable down-counter with an expiry flag. The master loads it when it
//   raises a fifo strobe and enables counting while waiting for the ack.
//   The counter stops at zero instead of wrapping.
// Ports
//   i_clk       clock
//   i_rst       synchronous active-high reset (counter -> 0)
//   i_load      load i_load_val this cycle (wins over i_en)
//   i_load_val  value loaded into the counter
//   i_en        decrement by one this cycle (stops at zero)
//   o_expired   counter is zero
//   o_cnt       current counter value
module ack_timer #(
  parameter int TW = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_load,
  input  logic [TW-1:0] i_load_val,
  input  logic          i_en,
  output logic          o_expired,
  output logic [TW-1:0] o_cnt
);

  logic [TW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = i_load_val;
    end else if (i_en && (cnt_q != '0)) begin
      cnt_d = cnt_q - TW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_expired = (cnt_q == '0);
  assign o_cnt     = cnt_q;

endmodule

// File: rtl/fifo_master.sv
// fifo_master
//   Initiator side of the fifo set/get pulse-ack protocol. Turns client push/pop
//   level requests into single fifo transactions, tracks occupancy (the fifo has
//   no flags of its own), refuses overflow/underflow and aborts a transaction
//   whose ack does not arrive within TIMEOUT wait cycles.
//
// Handshake: the client raises i_push or i_pop and holds it until it sees
//   o_push_done / o_pop_done / o_req_err. Requests are only looked at in IDLE.
//   Toward the fifo, o_fifo_set / o_fifo_get stay high until the matching ack
//   (i_fifo_set / i_fifo_get) is seen or the wait times out; the master then
//   keeps both strobes low for one DONE cycle so the fifo ack can fall.
//
// Ports
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_push, i_push_data          client write request (level) and data
//   i_pop                        client read request (level)
//   i_clr_err                    clears sticky o_err (a new error the same cycle wins)
//   o_push_done, o_pop_done      1-cycle completion pulses
//   o_pop_data                   read data, held until the next pop completes
//   o_req_err                    1-cycle pulse: refused or timed out
//   o_count, o_full, o_empty     occupancy and flags derived from it
//   o_err                        sticky {timeout, overflow|underflow}
//   o_fifo_en/set/get/data       strobes and write data toward the fifo
//   i_fifo_set/get/data          fifo acks and read data
module fifo_master
  import fifo_master_pkg::*;
#(
  parameter  int WIDTH   = 8,
  parameter  int DEPTH   = 256,
  parameter  int TIMEOUT = 15,
  localparam int CW      = cnt_width(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  input  logic             i_clr_err,
  output logic             o_push_done,
  output logic             o_pop_done,
  output logic [WIDTH-1:0] o_pop_data,
  output logic             o_req_err,
  output logic [CW-1:0]    o_count,
  output logic             o_full,
  output logic             o_empty,
  output logic [1:0]       o_err,
  output logic             o_fifo_en,
  output logic             o_fifo_set,
  output logic             o_fifo_get,
  output logic [WIDTH-1:0] o_fifo_data,
  input  logic             i_fifo_set,
  input  logic             i_fifo_get,
  input  logic [WIDTH-1:0] i_fifo_data
);

  localparam int TW = cnt_width(TIMEOUT);

  fm_state_e        state_d, state_q;
  logic [WIDTH-1:0] data_d, data_q;
  logic [WIDTH-1:0] pop_data_d, pop_data_q;
  logic [CW-1:0]    count_d, count_q;
  logic [1:0]       err_d, err_q;
  logic             push_done_d, push_done_q;
  logic             pop_done_d, pop_done_q;
  logic             req_err_d, req_err_q;
  logic             fifo_en_d, fifo_en_q;
  logic             fifo_set_d, fifo_set_q;
  logic             fifo_get_d, fifo_get_q;

  logic             full, empty;
  logic             tmr_load, tmr_en, tmr_expired;
  logic [TW-1:0]    tmr_cnt;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // Loaded with TIMEOUT-1 as the strobe rises, so it reaches zero on the
  // TIMEOUT-th wait cycle; an ack seen on that same cycle still completes.
  ack_timer #(
    .TW (TW)
  ) u_ack_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (tmr_load),
    .i_load_val (TW'(TIMEOUT - 1)),
    .i_en       (tmr_en),
    .o_expired  (tmr_expired),
    .o_cnt      (tmr_cnt)
  );

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    pop_data_d  = pop_data_q;
    count_d     = count_q;
    err_d       = i_clr_err ? 2'b00 : err_q;
    push_done_d = 1'b0;
    pop_done_d  = 1'b0;
    req_err_d   = 1'b0;
    fifo_en_d   = 1'b1;
    fifo_set_d  = 1'b0;
    fifo_get_d  = 1'b0;
    tmr_load    = 1'b0;
    tmr_en      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Pop has priority, but only when there is something to pop; with
        // both requests high on an empty fifo the push goes first.
        if (i_pop && !empty) begin
          state_d    = ST_GET_WAIT;
          fifo_get_d = 1'b1;
          tmr_load   = 1'b1;
        end else if (i_push) begin
          if (full) begin
            req_err_d       = 1'b1;
            err_d[ERR_OVUN] = 1'b1;
          end else begin
            state_d    = ST_SET_WAIT;
            data_d     = i_push_data;
            fifo_set_d = 1'b1;
            tmr_load   = 1'b1;
          end
        end else if (i_pop) begin
          req_err_d       = 1'b1;
          err_d[ERR_OVUN] = 1'b1;
        end
      end

      ST_SET_WAIT: begin
        tmr_en = 1'b1;
        if (i_fifo_set) begin
          push_done_d = 1'b1;
          count_d     = count_q + CW'(1);
          state_d     = ST_DONE;
        end else if (tmr_expired) begin
          req_err_d          = 1'b1;
          err_d[ERR_TIMEOUT] = 1'b1;
          state_d            = ST_DONE;
        end else begin
          fifo_set_d = 1'b1;
        end
      end

      ST_GET_WAIT: begin
        tmr_en = 1'b1;
        if (i_fifo_get) begin
          pop_data_d = i_fifo_data;
          pop_done_d = 1'b1;
          count_d    = count_q - CW'(1);
          state_d    = ST_DONE;
        end else if (tmr_expired) begin
          req_err_d          = 1'b1;
          err_d[ERR_TIMEOUT] = 1'b1;
          state_d            = ST_DONE;
        end else begin
          fifo_get_d = 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      data_q      <= '0;
      pop_data_q  <= '0;
      count_q     <= '0;
      err_q       <= 2'b00;
      push_done_q <= 1'b0;
      pop_done_q  <= 1'b0;
      req_err_q   <= 1'b0;
      fifo_en_q   <= 1'b0;
      fifo_set_q  <= 1'b0;
      fifo_get_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      pop_data_q  <= pop_data_d;
      count_q     <= count_d;
      err_q       <= err_d;
      push_done_q <= push_done_d;
      pop_done_q  <= pop_done_d;
      req_err_q   <= req_err_d;
      fifo_en_q   <= fifo_en_d;
      fifo_set_q  <= fifo_set_d;
      fifo_get_q  <= fifo_get_d;
    end
  end

  assign o_push_done = push_done_q;
  assign o_pop_done  = pop_done_q;
  assign o_pop_data  = pop_data_q;
  assign o_req_err   = req_err_q;
  assign o_count     = count_q;
  assign o_full      = full;
  assign o_empty     = empty;
  assign o_err       = err_q;
  assign o_fifo_en   = fifo_en_q;
  assign o_fifo_set  = fifo_set_q;
  assign o_fifo_get  = fifo_get_q;
  assign o_fifo_data = data_q;

endmodule

// File: tb/tb_fifo_master.sv
// tb_fifo_master
//   Directed bench for fifo_master with DEPTH=4 against a small behavioural fifo
//   responder whose acks can be disabled. Pop data goes through a scoreboard:
//   the expected byte is queued when the pop is issued and a monitor compares
//   it whenever o_pop_done is seen.
module tb_fifo_master;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int T  = 15;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_push, i_pop, i_clr_err;
  logic [W-1:0]  i_push_data;
  logic          o_push_done, o_pop_done, o_req_err, o_full, o_empty;
  logic [W-1:0]  o_pop_data, o_fifo_data;
  logic [CW-1:0] o_count;
  logic [1:0]    o_err;
  logic          o_fifo_en, o_fifo_set, o_fifo_get;
  logic          f_set_q, f_get_q;
  logic [W-1:0]  f_data_q;
  logic          ack_en;

  always #5 clk = ~clk;

  fifo_master #(.WIDTH(W), .DEPTH(D), .TIMEOUT(T)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_push      (i_push),
    .i_push_data (i_push_data),
    .i_pop       (i_pop),
    .i_clr_err   (i_clr_err),
    .o_push_done (o_push_done),
    .o_pop_done  (o_pop_done),
    .o_pop_data  (o_pop_data),
    .o_req_err   (o_req_err),
    .o_count     (o_count),
    .o_full      (o_full),
    .o_empty     (o_empty),
    .o_err       (o_err),
    .o_fifo_en   (o_fifo_en),
    .o_fifo_set  (o_fifo_set),
    .o_fifo_get  (o_fifo_get),
    .o_fifo_data (o_fifo_data),
    .i_fifo_set  (f_set_q),
    .i_fifo_get  (f_get_q),
    .i_fifo_data (f_data_q)
  );

  // Behavioural fifo: registered ack one cycle after the strobe, held until the
  // strobe drops; each strobe moves exactly one word.
  logic [W-1:0] fmem [D];
  logic [1:0]   wp, rp;

  always @(posedge clk) begin
    if (rst) begin
      wp <= 2'd0; rp <= 2'd0; f_set_q <= 1'b0; f_get_q <= 1'b0; f_data_q <= '0;
    end else begin
      if (!o_fifo_set) f_set_q <= 1'b0;
      else if (o_fifo_en && ack_en && !f_set_q) begin
        fmem[wp] <= o_fifo_data; wp <= wp + 2'd1; f_set_q <= 1'b1;
      end
      if (!o_fifo_get) f_get_q <= 1'b0;
      else if (o_fifo_en && ack_en && !f_get_q) begin
        f_data_q <= fmem[rp]; rp <= rp + 2'd1; f_get_q <= 1'b1;
      end
    end
  end

  // Scoreboard
  int           vec_cnt = 0;
  int           err_cnt = 0;
  logic [W-1:0] exp_q [$];
  logic [W-1:0] exp_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (o_pop_done) begin
      if (exp_q.size() == 0) begin
        vec_cnt++;
        err_cnt++;
        $display("FAIL pop_unexpected: got pop_done data 0x%0h, expected none (t=%0t)", o_pop_data, $time);
      end else begin
        exp_b = exp_q.pop_front();
        check("pop_data", 32'(o_pop_data), 32'(exp_b));
      end
    end
  end

  // Driver: issue one request, hold it until a done/err pulse, record timing.
  // Index i counts negedges from the cycle the request is first presented.
  int   r_lat, r_strobe_at, r_strobe_n;
  logic r_done, r_err;

  task automatic req(input logic is_pop, input logic [W-1:0] d);
    @(posedge clk); #1;
    if (is_pop) i_pop = 1'b1;
    else begin i_push = 1'b1; i_push_data = d; end
    r_lat = -1; r_strobe_at = -1; r_strobe_n = 0; r_done = 1'b0; r_err = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (o_fifo_set || o_fifo_get) begin
        if (r_strobe_at < 0) r_strobe_at = i;
        r_strobe_n++;
      end
      if (o_push_done || o_pop_done || o_req_err) begin
        r_lat = i; r_done = o_push_done | o_pop_done; r_err = o_req_err;
        break;
      end
    end
    i_push = 1'b0; i_pop = 1'b0;
    if (r_lat < 0) begin
      vec_cnt++; err_cnt++;
      $display("FAIL req_bound: got no response in 40 cycles, expected done or err");
    end
  endtask

  // Both requests high; drop whichever one completes first, keep the other.
  logic s1_push, s1_pop, s2_push, s2_pop;

  task automatic dual(input logic [W-1:0] d);
    int n;
    @(posedge clk); #1;
    i_push = 1'b1; i_pop = 1'b1; i_push_data = d;
    s1_push = 0; s1_pop = 0; s2_push = 0; s2_pop = 0;
    for (n = 0; n < 40; n++) begin
      @(negedge clk);
      if (o_push_done || o_pop_done) break;
    end
    s1_push = o_push_done; s1_pop = o_pop_done;
    if (o_push_done) i_push = 1'b0;
    if (o_pop_done)  i_pop  = 1'b0;
    for (n = 0; n < 40; n++) begin
      @(negedge clk);
      if (o_push_done || o_pop_done) break;
    end
    s2_push = o_push_done; s2_pop = o_pop_done;
    i_push = 1'b0; i_pop = 1'b0;
  endtask

  task automatic clear_err();
    @(posedge clk); #1; i_clr_err = 1'b1;
    @(posedge clk); #1; i_clr_err = 1'b0;
    @(negedge clk);
    check("err_cleared", 32'(o_err), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish, expected run to end");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; i_push = 0; i_pop = 0; i_clr_err = 0; i_push_data = '0; ack_en = 1'b1;
    repeat (3) @(negedge clk);
    // Reset state
    check("rst_count", 32'(o_count), 32'd0);
    check("rst_empty", 32'(o_empty), 32'd1);
    check("rst_full",  32'(o_full),  32'd0);
    check("rst_en",    32'(o_fifo_en), 32'd0);
    check("rst_strobes", 32'({o_fifo_set, o_fifo_get}), 32'd0);
    check("rst_pulses", 32'({o_push_done, o_pop_done, o_req_err}), 32'd0);
    check("rst_err",   32'(o_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("en_after_rst", 32'(o_fifo_en), 32'd1);

    // 1. single push: strobe one cycle later, done three cycles after request
    req(1'b0, 8'hA5);
    check("t1_strobe_at", 32'(r_strobe_at), 32'd1);
    check("t1_latency",   32'(r_lat), 32'd3);
    check("t1_done",      32'(r_done), 32'd1);
    check("t1_count",     32'(o_count), 32'd1);
    check("t1_empty",     32'(o_empty), 32'd0);
    exp_q.push_back(8'hA5);
    req(1'b1, '0);
    check("t1_pop_latency", 32'(r_lat), 32'd3);
    check("t1_pop_count",   32'(o_count), 32'd0);

    // 2. three pushes then three pops, in order
    req(1'b0, 8'h11); req(1'b0, 8'h22); req(1'b0, 8'h33);
    check("t2_count3", 32'(o_count), 32'd3);
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    repeat (3) req(1'b1, '0);
    check("t2_empty", 32'(o_empty), 32'd1);
    check("t2_pop_data_held", 32'(o_pop_data), 32'h33);

    // 3. fill to DEPTH, overflow refused with no strobe
    req(1'b0, 8'h01); req(1'b0, 8'h02); req(1'b0, 8'h03); req(1'b0, 8'h04);
    check("t3_full",  32'(o_full),  32'd1);
    check("t3_count", 32'(o_count), 32'd4);
    req(1'b0, 8'h55);
    check("t3_req_err",   32'(r_err), 32'd1);
    check("t3_no_done",   32'(r_done), 32'd0);
    check("t3_err_lat",   32'(r_lat), 32'd1);
    check("t3_no_strobe", 32'(r_strobe_at), 32'hFFFF_FFFF);
    check("t3_count",     32'(o_count), 32'd4);
    check("t3_err",       32'(o_err), 32'b01);
    clear_err();
    exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'h03); exp_q.push_back(8'h04);
    repeat (4) req(1'b1, '0);
    // underflow refused
    req(1'b1, '0);
    check("t3_underflow_err", 32'(r_err), 32'd1);
    check("t3_underflow_flag", 32'(o_err), 32'b01);
    check("t3_underflow_count", 32'(o_count), 32'd0);
    clear_err();

    // 4. push+pop together on empty: push first, then pop returns it
    exp_q.push_back(8'h66);
    dual(8'h66);
    check("t4_first_push",  32'({s1_push, s1_pop}), 32'b10);
    check("t4_second_pop",  32'({s2_push, s2_pop}), 32'b01);
    check("t4_count",       32'(o_count), 32'd0);
    // not empty: pop wins
    req(1'b0, 8'h99);
    exp_q.push_back(8'h99);
    dual(8'h44);
    check("t4b_first_pop",   32'({s1_push, s1_pop}), 32'b01);
    check("t4b_second_push", 32'({s2_push, s2_pop}), 32'b10);
    check("t4b_count",       32'(o_count), 32'd1);
    exp_q.push_back(8'h44);
    req(1'b1, '0);

    // 5. missing ack times out
    ack_en = 1'b0;
    req(1'b0, 8'h5A);
    check("t5_req_err",   32'(r_err), 32'd1);
    check("t5_no_done",   32'(r_done), 32'd0);
    check("t5_err_lat",   32'(r_lat), 32'(T + 1));
    check("t5_strobe_n",  32'(r_strobe_n), 32'(T));
    check("t5_count",     32'(o_count), 32'd0);
    check("t5_err",       32'(o_err), 32'b10);
    ack_en = 1'b1;
    clear_err();

    // 6. reset during GET_WAIT aborts with no pop_done
    req(1'b0, 8'h77);
    check("t6_count1", 32'(o_count), 32'd1);
    ack_en = 1'b0;
    @(posedge clk); #1; i_pop = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t6_in_get_wait", 32'(o_fifo_get), 32'd1);
    rst = 1'b1; i_pop = 1'b0;
    @(negedge clk);
    check("t6_strobes",  32'({o_fifo_set, o_fifo_get}), 32'd0);
    check("t6_count",    32'(o_count), 32'd0);
    check("t6_empty",    32'(o_empty), 32'd1);
    check("t6_no_done",  32'(o_pop_done), 32'd0);
    rst = 1'b0; ack_en = 1'b1;
    @(negedge clk);
    check("t6_en", 32'(o_fifo_en), 32'd1);
    req(1'b0, 8'h88);
    check("t6_post_latency", 32'(r_lat), 32'd3);
    exp_q.push_back(8'h88);
    req(1'b1, '0);
    check("t6_post_count", 32'(o_count), 32'd0);

    repeat (3) @(negedge clk);
    vec_cnt++;
    if (exp_q.size() != 0) begin
      err_cnt++;
      $display("FAIL sb_drain: got %0d pops outstanding, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
